fish_motion_ctrl: RTL and testbench

//  Sequencer for one Bits-wide load/bidirectional shift register holding a fish lane.

---
 rtl/fish_pkg.sv | 18 +
 rtl/fish_tick_div.sv | 54 +++++
 rtl/fish_motion_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fish_motion_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fish_pkg.sv
// Shared definitions for the fish lane motion sequencer.
package fish_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fish_state_e;

  // Direction encoding: 1 moves towards the MSB, 0 towards the LSB.
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Shortest step period; one clock for the command, one for the register to settle.
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/fish_tick_div.sv
// Step-period divider: counts 0..P-1 with P = max(period, MIN_PERIOD) and
// flags the last count. The period is re-sampled on every clear and every wrap.
module fish_tick_div
  import fish_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          en,
  input  logic [PW-1:0] period,
  output logic          step
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] per_clamped;

  // Clamp the requested period, detect the last count and advance the counter.
  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (period < PW'(MIN_PERIOD)) begin
      per_clamped = PW'(MIN_PERIOD);
    end else begin
      per_clamped = period;
    end
    step = en && (cnt_q == (per_q - {{(PW-1){1'b0}}, 1'b1}));
    if (clr) begin
      cnt_d = {PW{1'b0}};
      per_d = per_clamped;
    end else if (step) begin
      cnt_d = {PW{1'b0}};
      per_d = per_clamped;
    end else if (en) begin
      cnt_d = cnt_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and sampled-period registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= {PW{1'b0}};
      per_q <= PW'(MIN_PERIOD);
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/fish_motion_ctrl.sv
// Fish lane motion sequencer: loads a start pattern into the lane register,
// then issues one shift per period, left or right.
// Build option FISH_BOUNCE_EN: defined -> bounce off the lane edges;
// undefined -> bits fall off the edge and the pattern respawns on an empty lane.
module fish_motion_ctrl
  import fish_pkg::*;
#(
  parameter int Bits = 4,
  parameter int PW   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            stop,
  input  logic [Bits-1:0] pattern,
  input  logic            dirInit,
  input  logic [PW-1:0]   period,
  input  logic [Bits-1:0] regValue,
  output logic [Bits-1:0] loadValue,
  output logic            loadBit,
  output logic            shiftLeft,
  output logic            shiftRight,
  output logic            moving,
  output logic            edgeHit
);

  fish_state_e     state_q, state_d;
  logic            dir_q, dir_d;
  logic [Bits-1:0] pat_q, pat_d;
  logic [Bits-1:0] load_value_q, load_value_d;
  logic            load_bit_q, load_bit_d;
  logic            shift_left_q, shift_left_d;
  logic            shift_right_q, shift_right_d;
  logic            moving_q, moving_d;
  logic            edge_hit_q, edge_hit_d;
  logic            step;
  logic            tick_clr;
  logic            tick_en;
  logic            start_acc;
  logic            at_hi;
  logic            at_lo;

  assign tick_en   = (state_q == RUN);
  assign tick_clr  = (state_q != RUN);
  assign start_acc = start && (pattern != {Bits{1'b0}});
  assign at_hi     = regValue[Bits-1];
  assign at_lo     = regValue[0];

  fish_tick_div #(.PW(PW)) u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tick_clr),
    .en     (tick_en),
    .period (period),
    .step   (step)
  );

  // Next state and next output values; stop beats start, start beats a step.
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    pat_d         = pat_q;
    load_value_d  = {Bits{1'b0}};
    load_bit_d    = 1'b0;
    shift_left_d  = 1'b0;
    shift_right_d = 1'b0;
    edge_hit_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start_acc) begin
      state_d = LOAD;
      pat_d   = pattern;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOAD: begin
          load_bit_d   = 1'b1;
          load_value_d = pat_q;
          dir_d        = dirInit;
          state_d      = RUN;
        end
        RUN: begin
          state_d = RUN;
          if (step) begin
`ifdef FISH_BOUNCE_EN
            if (regValue == {Bits{1'b0}}) begin
              edge_hit_d = 1'b0;
            end else if (at_hi && at_lo) begin
              // Fish spans the whole lane: turn around without moving.
              dir_d      = ~dir_q;
              edge_hit_d = 1'b1;
            end else if ((dir_q == DIR_LEFT) && at_hi) begin
              dir_d         = DIR_RIGHT;
              edge_hit_d    = 1'b1;
              shift_right_d = 1'b1;
            end else if ((dir_q == DIR_RIGHT) && at_lo) begin
              dir_d        = DIR_LEFT;
              edge_hit_d   = 1'b1;
              shift_left_d = 1'b1;
            end else if (dir_q == DIR_LEFT) begin
              shift_left_d = 1'b1;
            end else begin
              shift_right_d = 1'b1;
            end
`else
            if (regValue == {Bits{1'b0}}) begin
              // Lane has emptied: respawn the captured pattern.
              load_bit_d   = 1'b1;
              load_value_d = pat_q;
              edge_hit_d   = 1'b1;
            end else if (dir_q == DIR_LEFT) begin
              shift_left_d = 1'b1;
            end else begin
              shift_right_d = 1'b1;
            end
`endif
          end else begin
            edge_hit_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    moving_d = (state_d == RUN);
  end

  // State, direction, captured pattern and output registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= IDLE;
      dir_q         <= DIR_LEFT;
      pat_q         <= {Bits{1'b0}};
      load_value_q  <= {Bits{1'b0}};
      load_bit_q    <= 1'b0;
      shift_left_q  <= 1'b0;
      shift_right_q <= 1'b0;
      moving_q      <= 1'b0;
      edge_hit_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      pat_q         <= pat_d;
      load_value_q  <= load_value_d;
      load_bit_q    <= load_bit_d;
      shift_left_q  <= shift_left_d;
      shift_right_q <= shift_right_d;
      moving_q      <= moving_d;
      edge_hit_q    <= edge_hit_d;
    end
  end

  assign loadValue  = load_value_q;
  assign loadBit    = load_bit_q;
  assign shiftLeft  = shift_left_q;
  assign shiftRight = shift_right_q;
  assign moving     = moving_q;
  assign edgeHit    = edge_hit_q;

endmodule

// File: tb/tb_fish_motion_ctrl.sv
// Bench for fish_motion_ctrl with a 4-bit lane register closing the feedback loop.
// A behavioural model predicts every output each cycle; directed scenarios add
// hand-computed expectations. Honours FISH_BOUNCE_EN like the design.
module tb_fish_motion_ctrl;

  logic       CLK;
  logic       RST;
  logic       start;
  logic       stop;
  logic [3:0] pattern;
  logic       dirInit;
  logic [7:0] period;
  logic [3:0] regValue;
  logic [3:0] loadValue;
  logic       loadBit;
  logic       shiftLeft;
  logic       shiftRight;
  logic       moving;
  logic       edgeHit;

  fish_motion_ctrl #(.Bits(4), .PW(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .stop       (stop),
    .pattern    (pattern),
    .dirInit    (dirInit),
    .period     (period),
    .regValue   (regValue),
    .loadValue  (loadValue),
    .loadBit    (loadBit),
    .shiftLeft  (shiftLeft),
    .shiftRight (shiftRight),
    .moving     (moving),
    .edgeHit    (edgeHit)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Lane register driven by the sequencer commands.
  always_ff @(posedge CLK) begin
    if (!RST)           regValue <= 4'd0;
    else if (loadBit)   regValue <= loadValue;
    else if (shiftLeft) regValue <= {regValue[2:0], 1'b0};
    else if (shiftRight) regValue <= {1'b0, regValue[3:1]};
    else                regValue <= regValue;
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Model: mode 0 idle, 1 loading, 2 running; m_left = clocks until next step.
  int m_mode = 0, m_dir = 1, m_pat = 0, m_left = 2, m_lane = 0;
  int e_load = 0, e_sl = 0, e_sr = 0, e_mov = 0, e_hit = 0, e_lv = 0;

  int pulse_q[$];
  int lane_seq[$];
  int last_lane = 0;
  int hit_cnt = 0;
  int load_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int clamp_p(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_step();
    int nl, n_load, n_sl, n_sr, n_hit, n_lv, hi, lo;
    if (!RST)          nl = 0;
    else if (e_load != 0) nl = e_lv;
    else if (e_sl != 0)   nl = (m_lane * 2) % 16;
    else if (e_sr != 0)   nl = m_lane / 2;
    else               nl = m_lane;
    n_load = 0; n_sl = 0; n_sr = 0; n_hit = 0; n_lv = 0;
    hi = (m_lane >= 8) ? 1 : 0;
    lo = m_lane % 2;
    if (!RST) begin
      m_mode = 0; m_dir = 1; m_pat = 0;
    end else if (stop) begin
      m_mode = 0;
    end else if (start && pattern != 4'd0) begin
      m_mode = 1; m_pat = int'(pattern);
    end else if (m_mode == 1) begin
      n_load = 1; n_lv = m_pat; m_dir = int'(dirInit);
      m_left = clamp_p(int'(period)); m_mode = 2;
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin
        m_left = clamp_p(int'(period));
`ifdef FISH_BOUNCE_EN
        if (m_lane == 0) begin
          n_hit = 0;
        end else if (hi == 1 && lo == 1) begin
          m_dir = 1 - m_dir; n_hit = 1;
        end else if ((m_dir == 1 && hi == 1) || (m_dir == 0 && lo == 1)) begin
          m_dir = 1 - m_dir; n_hit = 1;
          if (m_dir == 1) n_sl = 1; else n_sr = 1;
        end else begin
          if (m_dir == 1) n_sl = 1; else n_sr = 1;
        end
`else
        if (m_lane == 0) begin
          n_load = 1; n_lv = m_pat; n_hit = 1;
        end else begin
          if (m_dir == 1) n_sl = 1; else n_sr = 1;
        end
`endif
      end
    end
    e_load = n_load; e_sl = n_sl; e_sr = n_sr; e_hit = n_hit; e_lv = n_lv;
    e_mov  = (m_mode == 2) ? 1 : 0;
    m_lane = nl;
  endtask

  // Compare every DUT output and the lane register against the model.
  task automatic compare_outputs();
    int act_v, exp_v;
    act_v = int'({loadBit, shiftLeft, shiftRight, moving, edgeHit, loadValue, regValue});
    exp_v = (e_load << 12) | (e_sl << 11) | (e_sr << 10) | (e_mov << 9) |
            (e_hit << 8) | (e_lv << 4) | m_lane;
    check("outputs{ld,sl,sr,mov,hit,lv,lane}", act_v, exp_v);
    check("pulse_exclusive", ((int'(loadBit) + int'(shiftLeft) + int'(shiftRight)) <= 1) ? 1 : 0, 1);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    cyc++;
    compare_outputs();
    if (shiftLeft || shiftRight) pulse_q.push_back(cyc);
    if (int'(regValue) != last_lane) begin
      lane_seq.push_back(int'(regValue));
      last_lane = int'(regValue);
    end
    if (edgeHit) hit_cnt++;
    if (loadBit) load_cnt++;
  endtask

  task automatic go(input logic [3:0] pat, input logic dir, input logic [7:0] per);
    pattern = pat; dirInit = dir; period = per; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic gap_check(input string name, input int exp_gap);
    if (pulse_q.size() >= 2) check(name, pulse_q[1] - pulse_q[0], exp_gap);
    else check(name, -1, exp_gap);
  endtask

  int exp_seq[9];

  initial begin
    RST = 1'b0; start = 1'b0; stop = 1'b0; pattern = 4'd0; dirInit = 1'b1; period = 8'd3;

    // Reset held two cycles.
    tick(); tick();
    check("reset_moving", int'(moving), 0);
    check("reset_loadValue", int'(loadValue), 0);
    RST = 1'b1;

    // Load 0001 moving left with period 3, then follow the lane through an edge.
`ifdef FISH_BOUNCE_EN
    exp_seq = '{1, 2, 4, 8, 4, 2, 1, 2, 4};
`else
    exp_seq = '{1, 2, 4, 8, 0, 1, 2, 4, 8};
`endif
    lane_seq.delete(); pulse_q.delete(); last_lane = int'(regValue); hit_cnt = 0;
    go(4'b0001, 1'b1, 8'd3);
    repeat (30) tick();
    for (int i = 0; i < 9; i++)
      check($sformatf("lane_seq[%0d]", i), (i < lane_seq.size()) ? lane_seq[i] : -1, exp_seq[i]);
    gap_check("step_gap_p3", 3);
    check("edge_seen", (hit_cnt > 0) ? 1 : 0, 1);

    // Period clamp: 0 and 1 behave as 2; 5 is honoured.
    halt(); pulse_q.delete(); go(4'b0001, 1'b1, 8'd0); repeat (16) tick(); gap_check("step_gap_p0", 2);
    halt(); pulse_q.delete(); go(4'b0001, 1'b1, 8'd1); repeat (16) tick(); gap_check("step_gap_p1", 2);
    halt(); pulse_q.delete(); go(4'b0001, 1'b1, 8'd5); repeat (16) tick(); gap_check("step_gap_p5", 5);

    // Stop mid-run: no further commands, motion flag drops.
    halt(); go(4'b0001, 1'b1, 8'd3); repeat (7) tick();
    halt(); pulse_q.delete(); load_cnt = 0;
    repeat (10) tick();
    check("stop_no_pulses", pulse_q.size() + load_cnt, 0);
    check("stop_moving", int'(moving), 0);

    // Start and stop together stay idle.
    load_cnt = 0;
    pattern = 4'b0110; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    tick(); tick();
    check("start_stop_moving", int'(moving), 0);
    check("start_stop_no_load", load_cnt, 0);

    // Restart during RUN reloads the new pattern.
    go(4'b0001, 1'b1, 8'd3); repeat (6) tick();
    go(4'b0110, 1'b1, 8'd3); tick(); tick();
    check("restart_lane", int'(regValue), 6);
    check("restart_moving", int'(moving), 1);

    // A zero pattern is not accepted.
    halt(); load_cnt = 0;
    go(4'b0000, 1'b1, 8'd3); repeat (4) tick();
    check("zero_pattern_moving", int'(moving), 0);
    check("zero_pattern_no_load", load_cnt, 0);

    // Pattern touching both edges.
    halt(); pulse_q.delete(); hit_cnt = 0;
    go(4'b1001, 1'b1, 8'd2); repeat (12) tick();
`ifdef FISH_BOUNCE_EN
    check("both_edges_no_shift", pulse_q.size(), 0);
    check("both_edges_hits", hit_cnt, 5);
`else
    check("respawn_hits", hit_cnt, 1);
`endif

    // Randomised control traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      RST     = ($urandom_range(0, 299) != 0);
      stop    = ($urandom_range(0, 59) == 0);
      start   = ($urandom_range(0, 39) == 0);
      pattern = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      dirInit = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) period = 8'($urandom_range(0, 6));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
